obi_read_burst_manager: RTL and testbench

Synthesizable OBI read manager that turns a linear read descriptor (word-aligned start address, beat count) into a sequence of OBI read requests and returns the response data as a ready/valid stream with a last flag. It sits directly upstream of the OBI read subordinate model in the DMA test environment: its OBI manager port feeds that subordinate, and its data stream feeds the DMA write side or a scoreboard. It limits outstanding transactions with credits, so it never back-pressures the OBI R channel.

---
 rtl/obi_read_burst_pkg.sv | 10 +
 rtl/obi_read_burst_manager_fifo.sv | 76 +++++++
 rtl/obi_read_burst_manager_sva.sv | 29 ++
 rtl/obi_read_burst_manager.sv | 179 +++++++++++++++++
 tb/tb_obi_read_burst_manager.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_read_burst_pkg.sv
// Shared FSM encoding for the OBI read burst manager.
package obi_read_burst_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StDrain = 2'd2;

endpackage

// File: rtl/obi_read_burst_manager_fifo.sv
// Response buffer with the common_cells fifo_v3 interface; synchronous active-low reset.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [CntWidth-1:0]   r_count;
  logic                  w_mem_empty;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(DEPTH - 1)) begin
      return {PtrWidth{1'b0}};
    end else begin
      return ptr + PtrWidth'(1);
    end
  endfunction

  assign w_mem_empty = (r_count == {CntWidth{1'b0}});
  assign full_o      = (r_count == CntWidth'(DEPTH));
  // In fall-through mode a push into an empty FIFO popped in the same cycle is never stored.
  assign w_bypass    = FALL_THROUGH && w_mem_empty && push_i && pop_i;
  assign empty_o     = FALL_THROUGH ? (w_mem_empty && !push_i) : w_mem_empty;
  assign data_o      = (FALL_THROUGH && w_mem_empty) ? data_i : r_mem[r_rd_ptr];
  assign w_push      = push_i && !full_o && !w_bypass;
  assign w_pop       = pop_i && !w_mem_empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd_ptr <= {PtrWidth{1'b0}};
      r_wr_ptr <= {PtrWidth{1'b0}};
      r_count  <= {CntWidth{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (flush_i) begin
      r_rd_ptr <= {PtrWidth{1'b0}};
      r_wr_ptr <= {PtrWidth{1'b0}};
      r_count  <= {CntWidth{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obi_read_burst_manager_sva.sv
// Protocol checks for the OBI read burst manager, instantiated inside the top.
module obi_read_burst_manager_sva #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned CntWidth       = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  input logic                 obi_req_i,
  input logic                 obi_gnt_i,
  input logic [AddrWidth-1:0] obi_addr_i,
  input logic                 obi_rvalid_i,
  input logic [CntWidth-1:0]  pending_i,
  input logic [CntWidth-1:0]  credits_i
);

  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    obi_rvalid_i |-> (pending_i != CntWidth'(0)))
    else $error("OBI response without an outstanding request");

  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (obi_req_i && !obi_gnt_i) |=> (obi_req_i && $stable(obi_addr_i)))
    else $error("OBI request dropped or address changed before grant");

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credits_i <= CntWidth'(MaxOutstanding))
    else $error("credit counter above MaxOutstanding");

endmodule

// File: rtl/obi_read_burst_manager.sv
// OBI read manager: one linear descriptor becomes a credit-limited stream of OBI reads
// whose responses come back as a ready/valid beat stream with a last flag.
module obi_read_burst_manager
  import obi_read_burst_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LenWidth       = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic [AddrWidth-1:0]   desc_addr_i,
  input  logic [LenWidth-1:0]    desc_num_beats_i,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  input  logic                   obi_rvalid_i,
  output logic                   obi_rready_o,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic [DataWidth-1:0]   data_o,
  output logic                   data_err_o,
  output logic                   data_last_o,
  output logic                   busy_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [AddrWidth-1:0] AddrMask = ~AddrWidth'(BeWidth - 1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 err;
  } beat_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AddrWidth-1:0] r_addr;
  logic [LenWidth-1:0]  r_issue_left;
  logic [LenWidth-1:0]  r_num_beats;
  logic [LenWidth-1:0]  r_out_cnt;
  logic [CntWidth-1:0]  r_credits;
  logic [CntWidth-1:0]  r_pending;
  logic                 w_desc_hs;
  logic                 w_grant;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  beat_t                w_push_beat;
  beat_t                w_pop_beat;

  assign desc_ready_o = (r_state == StIdle);
  assign busy_o       = (r_state != StIdle);
  assign w_desc_hs    = desc_valid_i && desc_ready_o;
  // A request only goes out while a credit is free, so the FIFO can always absorb its response.
  assign obi_req_o    = (r_state == StIssue) && (r_credits != CntWidth'(0));
  assign obi_addr_o   = r_addr;
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = {BeWidth{1'b1}};
  assign w_grant      = obi_req_o && obi_gnt_i;

  assign obi_rready_o = !w_fifo_full;
  assign w_push       = obi_rvalid_i && obi_rready_o && (r_pending != CntWidth'(0));
  assign w_push_beat  = '{data: obi_rdata_i, err: obi_err_i};

  assign data_valid_o = !w_fifo_empty;
  assign data_o       = w_pop_beat.data;
  assign data_err_o   = w_pop_beat.err;
  assign data_last_o  = data_valid_o && (r_out_cnt == (r_num_beats - LenWidth'(1)));
  assign w_pop        = data_valid_o && data_ready_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DataWidth + 1),
    .DEPTH        (MaxOutstanding)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .data_i  (w_push_beat),
    .push_i  (w_push),
    .data_o  (w_pop_beat),
    .pop_i   (w_pop)
  );

  // Next-state decode for the descriptor FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_desc_hs && (desc_num_beats_i != {LenWidth{1'b0}})) begin
          w_state_nxt = StIssue;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StIssue: begin
        if (w_grant && (r_issue_left == LenWidth'(1))) begin
          w_state_nxt = StDrain;
        end else begin
          w_state_nxt = StIssue;
        end
      end
      StDrain: begin
        if (w_pop && data_last_o) begin
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StDrain;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, address/beat counters, credits and outstanding-response count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_addr       <= {AddrWidth{1'b0}};
      r_issue_left <= {LenWidth{1'b0}};
      r_num_beats  <= {LenWidth{1'b0}};
      r_out_cnt    <= {LenWidth{1'b0}};
      r_credits    <= CntWidth'(MaxOutstanding);
      r_pending    <= {CntWidth{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_desc_hs) begin
        r_addr       <= desc_addr_i & AddrMask;
        r_issue_left <= desc_num_beats_i;
        r_num_beats  <= desc_num_beats_i;
        r_out_cnt    <= {LenWidth{1'b0}};
      end else begin
        if (w_grant) begin
          r_addr       <= r_addr + AddrWidth'(BeWidth);
          r_issue_left <= r_issue_left - LenWidth'(1);
        end
        if (w_pop) begin
          r_out_cnt <= r_out_cnt + LenWidth'(1);
        end
      end
      case ({w_grant, w_pop})
        2'b10:   r_credits <= r_credits - CntWidth'(1);
        2'b01:   r_credits <= r_credits + CntWidth'(1);
        default: r_credits <= r_credits;
      endcase
      case ({w_grant, w_push})
        2'b10:   r_pending <= r_pending + CntWidth'(1);
        2'b01:   r_pending <= r_pending - CntWidth'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  obi_read_burst_manager_sva #(
    .AddrWidth      (AddrWidth),
    .CntWidth       (CntWidth),
    .MaxOutstanding (MaxOutstanding)
  ) i_sva (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .obi_req_i    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_i   (obi_addr_o),
    .obi_rvalid_i (obi_rvalid_i),
    .pending_i    (r_pending),
    .credits_i    (r_credits)
  );

endmodule

// File: tb/tb_obi_read_burst_manager.sv
// Scoreboard bench: descriptor stimulus pushes expected addresses/beats, a randomized OBI
// subordinate serves requests, and independent monitors pop and compare.
module tb_obi_read_burst_manager;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned MO = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            desc_valid_i = 1'b0;
  logic            desc_ready_o;
  logic [AW-1:0]   desc_addr_i = '0;
  logic [LW-1:0]   desc_num_beats_i = '0;
  logic            obi_req_o;
  logic            obi_gnt_i = 1'b0;
  logic [AW-1:0]   obi_addr_o;
  logic            obi_we_o;
  logic [DW/8-1:0] obi_be_o;
  logic            obi_rvalid_i = 1'b0;
  logic            obi_rready_o;
  logic [DW-1:0]   obi_rdata_i = '0;
  logic            obi_err_i = 1'b0;
  logic            data_valid_o;
  logic            data_ready_i = 1'b0;
  logic [DW-1:0]   data_o;
  logic            data_err_o;
  logic            data_last_o;
  logic            busy_o;

  obi_read_burst_manager #(
    .AddrWidth(AW), .DataWidth(DW), .LenWidth(LW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_addr_i(desc_addr_i), .desc_num_beats_i(desc_num_beats_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o),
    .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
    .data_err_o(data_err_o), .data_last_o(data_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; logic err; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; int unsigned due; } rsp_t;

  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  rsp_t          rsp_q[$];
  int unsigned   gnt_cyc_q[$], rv_cyc_q[$], pop_cyc_q[$];

  int            checks = 0, failures = 0;
  int            gnt_max = 0, rsp_max = 0, rdy_mode = 0;
  int            grant_cnt = 0, pop_cnt = 0;
  logic          err_en = 1'b0, log_en = 1'b0, idle_chk = 1'b0;
  logic [AW-1:0] err_addr = '0;

  // Subordinate memory contents: a fixed function of the word address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // OBI subordinate and downstream ready driver; drives just after the falling edge.
  initial begin : subordinate
    int gnt_wait;
    gnt_wait = 0;
    forever begin
      @(negedge clk_i); #1;
      if (!rst_ni) begin
        rsp_q.delete();
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; data_ready_i = 1'b0; gnt_wait = 0;
      end else begin
        data_ready_i = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        obi_gnt_i = 1'b0;
        if (obi_req_o) begin
          if (gnt_wait == 0) obi_gnt_i = 1'b1;
          else gnt_wait--;
        end
        obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          obi_rvalid_i = 1'b1;
          obi_rdata_i  = mem_word(rsp_q[0].addr);
          obi_err_i    = err_en && (rsp_q[0].addr == err_addr);
          if (log_en) rv_cyc_q.push_back(cyc);
          if (obi_rready_o) void'(rsp_q.pop_front());
        end
        if (obi_req_o && obi_gnt_i) begin
          rsp_q.push_back('{obi_addr_o, cyc + 1 + $urandom_range(0, rsp_max)});
          gnt_wait = $urandom_range(0, gnt_max);
        end
      end
    end
  end

  // Request monitor: every granted address must match the model's next address.
  initial begin : req_monitor
    forever begin
      @(negedge clk_i); #2;
      if (rst_ni && obi_req_o && obi_gnt_i) begin
        grant_cnt++;
        if (log_en) gnt_cyc_q.push_back(cyc);
        if (exp_addr_q.size() == 0) check("unexpected_grant", obi_req_o, 1'b0);
        else check("req_addr", obi_addr_o, exp_addr_q.pop_front());
      end
    end
  end

  // Output monitor: every handshaked beat must match the model's next beat.
  initial begin : out_monitor
    beat_t e;
    forever begin
      @(negedge clk_i); #2;
      if (!rst_ni) begin
        idle_chk = 1'b0;
      end else begin
        if (idle_chk) begin
          idle_chk = 1'b0;
          check("idle_after_last", {desc_ready_o, busy_o}, 2'b10);
        end
        if (data_valid_o && data_ready_i) begin
          pop_cnt++;
          if (log_en) pop_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_beat", data_valid_o, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", data_o, e.data);
            check("beat_err", data_err_o, e.err);
            check("beat_last", data_last_o, e.last);
            if (e.last) idle_chk = 1'b1;
          end
        end
      end
    end
  end

  // Reference model: a descriptor is a list of word addresses, each returning one beat.
  task automatic send_desc(input logic [AW-1:0] addr, input int n, input int err_idx);
    logic [AW-1:0] base, a;
    int t;
    beat_t b;
    base = addr & ~32'h3;
    @(negedge clk_i); #1;
    desc_valid_i = 1'b1; desc_addr_i = addr; desc_num_beats_i = LW'(n);
    t = 0;
    while (!desc_ready_o && t < 2000) begin
      @(negedge clk_i); #1; t++;
    end
    check("desc_accept", desc_ready_o, 1'b1);
    err_en   = (err_idx >= 0);
    err_addr = base + 32'(4 * err_idx);
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      exp_addr_q.push_back(a);
      b.data = mem_word(a); b.err = (i == err_idx); b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    @(negedge clk_i); #1;
    desc_valid_i = 1'b0;
    #1;
    if (n > 0) begin
      check("first_req", obi_req_o, 1'b1);
      check("first_addr", obi_addr_o, base);
    end else begin
      check("zero_len_idle", {busy_o, obi_req_o, desc_ready_o}, 3'b001);
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 3000) begin
      @(negedge clk_i); #3; t++;
    end
    check(name, {exp_q.size() != 0, busy_o}, 2'b00);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {desc_ready_o, obi_req_o, obi_rready_o, data_valid_o,
                 data_err_o, data_last_o, busy_o}, 7'b1010000);
    check({name, "_addr"}, obi_addr_o, 32'h0);
    check({name, "_data"}, data_o, 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int g0, p0, t, n;
    logic [AW-1:0] a0;

    repeat (3) @(negedge clk_i);
    #2;
    check_reset_vals("reset");
    check("reset_we_be", {obi_we_o, obi_be_o}, 5'b01111);
    @(negedge clk_i); rst_ni = 1'b1;

    // Basic burst: back-to-back issue and one-cycle FIFO latency.
    log_en = 1'b1;
    send_desc(32'h0000_1000, 4, -1);
    wait_done("basic_done");
    log_en = 1'b0;
    check("basic_grants", gnt_cyc_q.size(), 4);
    check("basic_pops", pop_cyc_q.size(), 4);
    for (int i = 1; i < gnt_cyc_q.size(); i++)
      check("basic_b2b", gnt_cyc_q[i] - gnt_cyc_q[i-1], 1);
    for (int i = 0; i < pop_cyc_q.size() && i < rv_cyc_q.size(); i++)
      check("basic_rsp_latency", pop_cyc_q[i] - rv_cyc_q[i], 1);

    // Zero-length descriptor.
    g0 = grant_cnt; p0 = pop_cnt;
    send_desc(32'h0000_2000, 0, -1);
    repeat (4) @(negedge clk_i);
    #3;
    check("zero_len_no_req", grant_cnt - g0, 0);
    check("zero_len_no_beat", pop_cnt - p0, 0);

    // Address wrap.
    send_desc(32'hFFFF_FFF8, 4, -1);
    wait_done("wrap_done");

    // Downstream stall: credits cap the grants.
    rdy_mode = 1;
    g0 = grant_cnt;
    send_desc(32'h0000_3000, 10, -1);
    repeat (30) @(negedge clk_i);
    #3;
    check("stall_grants", grant_cnt - g0, MO);
    a0 = obi_addr_o;
    check("stall_addr", a0, 32'h0000_3010);
    repeat (5) @(negedge clk_i);
    #3;
    check("stall_addr_stable", obi_addr_o, a0);
    check("stall_no_more_grants", grant_cnt - g0, MO);
    rdy_mode = 0;
    wait_done("stall_done");

    // Random delays with an error on the second beat.
    gnt_max = 5; rsp_max = 5; rdy_mode = 2;
    send_desc(32'h0000_4000, 6, 1);
    wait_done("err_done");

    // Random descriptors.
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 12);
      send_desc($urandom, n, int'($urandom_range(0, n)) - 1);
      wait_done("rand_done");
    end

    // Reset in the middle of a burst.
    gnt_max = 1; rsp_max = 2; rdy_mode = 0;
    p0 = pop_cnt;
    send_desc(32'h0000_5000, 8, -1);
    t = 0;
    while (pop_cnt - p0 < 2 && t < 500) begin
      @(negedge clk_i); #3; t++;
    end
    check("midreset_two_beats", pop_cnt - p0, 2);
    @(negedge clk_i);
    rst_ni = 1'b0;
    exp_q.delete(); exp_addr_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #2;
    check_reset_vals("midreset");
    send_desc(32'h0000_6000, 2, -1);
    wait_done("after_reset_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
